traffic_sensor: RTL and testbench

TRAFFIC_SENSOR -- requirements
Module: traffic_sensor

---
 rtl/traffic_pkg.sv | 15 +
 rtl/sensor_filter.sv | 57 +++++
 rtl/traffic_sensor.sv | 89 ++++++++
 tb/tb_traffic_sensor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the traffic sensor front end.
package traffic_pkg;

    localparam int CNT_W            = 8;
    localparam int DB_CYCLES_DEF    = 8;
    localparam int STUCK_CYCLES_DEF = 200;

    typedef logic [CNT_W-1:0] cnt_t;

    // Increment that holds at lim instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v, input cnt_t lim);
        return (v == lim) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/sensor_filter.sv
// One approach: two-flop synchronizer, debounce filter, rising-edge pulse and stuck flag.
module sensor_filter
    import traffic_pkg::*;
#(
    parameter int DB_CYCLES    = DB_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic RAW,
    output logic RISE,
    output logic STUCK
);

    localparam cnt_t DB_LAST = cnt_t'(DB_CYCLES - 1);
    localparam cnt_t STK_MAX = cnt_t'(STUCK_CYCLES);

    logic sync1;
    logic sync2;
    logic f_q;
    logic f_d;
    cnt_t db_cnt;
    cnt_t stk_cnt;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            f_q     <= 1'b0;
            f_d     <= 1'b0;
            db_cnt  <= '0;
            stk_cnt <= '0;
        end else begin
            sync1 <= RAW;
            sync2 <= sync1;
            f_d   <= f_q;
            // The DB_CYCLES-th consecutive mismatching sample flips the level.
            if (sync2 == f_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                f_q    <= ~f_q;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + cnt_t'(1);
            end
            if (!f_q) begin
                stk_cnt <= '0;
            end else begin
                stk_cnt <= sat_inc(stk_cnt, STK_MAX);
            end
        end
    end

    assign RISE  = f_q & ~f_d;
    assign STUCK = (stk_cnt == STK_MAX);

endmodule

// File: rtl/traffic_sensor.sv
// Two-approach vehicle sensor: filtered detectors, demand latches and cross-demand T output.
module traffic_sensor
    import traffic_pkg::*;
#(
    parameter int DB_CYCLES    = DB_CYCLES_DEF,
    parameter int STUCK_CYCLES = STUCK_CYCLES_DEF
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       SN_RAW,
    input  logic       SE_RAW,
    input  logic       RN,
    output logic       T,
    output logic       DN,
    output logic       DE,
    output logic [1:0] FAULT
);

    logic rise_n;
    logic rise_e;
    logic stuck_n;
    logic stuck_e;
    logic rn_q;
    logic dn_q;
    logic de_q;
    logic t_q;
    logic north_served;
    logic east_served;
    logic dn_eff;
    logic de_eff;

    sensor_filter #(
        .DB_CYCLES   (DB_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_north (
        .CLK  (CLK),
        .CLR_N(CLR_N),
        .RAW  (SN_RAW),
        .RISE (rise_n),
        .STUCK(stuck_n)
    );

    sensor_filter #(
        .DB_CYCLES   (DB_CYCLES),
        .STUCK_CYCLES(STUCK_CYCLES)
    ) u_east (
        .CLK  (CLK),
        .CLR_N(CLR_N),
        .RAW  (SE_RAW),
        .RISE (rise_e),
        .STUCK(stuck_e)
    );

    // North is served when the controller turns north green, east when it turns north red.
    assign north_served = ~RN & rn_q;
    assign east_served  = RN & ~rn_q;

    // A stuck sensor keeps its approach in demand so the intersection never starves it.
    assign dn_eff = dn_q | stuck_n;
    assign de_eff = de_q | stuck_e;

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            rn_q <= 1'b0;
            dn_q <= 1'b0;
            de_q <= 1'b0;
            t_q  <= 1'b0;
        end else begin
            rn_q <= RN;
            if (rise_n) begin
                dn_q <= 1'b1;
            end else if (north_served) begin
                dn_q <= 1'b0;
            end
            if (rise_e) begin
                de_q <= 1'b1;
            end else if (east_served) begin
                de_q <= 1'b0;
            end
            t_q <= rn_q ? dn_eff : de_eff;
        end
    end

    assign T     = t_q;
    assign DN    = dn_q;
    assign DE    = de_q;
    assign FAULT = {stuck_e, stuck_n};

endmodule

// File: tb/tb_traffic_sensor.sv
// Directed self-checking bench for traffic_sensor with default DB=8, STUCK=200.
module tb_traffic_sensor;

  logic       CLK;
  logic       CLR_N;
  logic       SN_RAW;
  logic       SE_RAW;
  logic       RN;
  logic       T;
  logic       DN;
  logic       DE;
  logic [1:0] FAULT;

  int n_tests;
  int n_fail;
  logic seen;

  traffic_sensor dut (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .SN_RAW(SN_RAW),
    .SE_RAW(SE_RAW),
    .RN    (RN),
    .T     (T),
    .DN    (DN),
    .DE    (DE),
    .FAULT (FAULT)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // driver helpers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    CLR_N   = 1'b0;
    SN_RAW  = 1'b0;
    SE_RAW  = 1'b0;
    RN      = 1'b0;
    tick(2);
    check("reset_outputs", {3'b0, T, DN, DE, FAULT}, 8'h00);
    CLR_N = 1'b1;
    tick(2);

    // East rise with north green: DE at edge 10, T at edge 11
    SE_RAW = 1'b1;
    tick(10);
    check("de_before_edge10", {7'b0, DE}, 8'h00);
    tick(1);
    check("de_at_edge10", {7'b0, DE}, 8'h01);
    check("t_before_edge11", {7'b0, T}, 8'h00);
    tick(1);
    check("t_at_edge11", {7'b0, T}, 8'h01);
    check("dn_idle", {7'b0, DN}, 8'h00);

    // North turns red: east served, T follows north demand
    RN = 1'b1;
    tick(1);
    check("de_served", {7'b0, DE}, 8'h00);
    check("t_old_rn_q", {7'b0, T}, 8'h01);
    tick(1);
    check("t_to_dn", {7'b0, T}, 8'h00);
    SE_RAW = 1'b0;
    tick(12);
    check("fault_idle", {6'b0, FAULT}, 8'h00);

    // Short north pulses must be filtered out entirely
    seen = 1'b0;
    repeat (4) begin
      SN_RAW = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tick(1);
        seen |= DN | T | (|FAULT);
      end
      SN_RAW = 1'b0;
      for (int i = 0; i < 2; i++) begin
        tick(1);
        seen |= DN | T | (|FAULT);
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen |= DN | T | (|FAULT);
    end
    check("glitch_no_effect", {7'b0, seen}, 8'h00);

    // North held: DN at edge 10, T at 11, stuck flag at edge 209
    SN_RAW = 1'b1;
    tick(10);
    check("dn_before_edge10", {7'b0, DN}, 8'h00);
    tick(1);
    check("dn_at_edge10", {7'b0, DN}, 8'h01);
    tick(1);
    check("t_north_demand", {7'b0, T}, 8'h01);
    seen = 1'b0;
    for (int k = 12; k < 209; k++) begin
      tick(1);
      seen |= ~T;
    end
    check("t_held_while_rn", {7'b0, seen}, 8'h00);
    check("fault_before_200", {6'b0, FAULT}, 8'h00);
    tick(1);
    check("fault_north_set", {6'b0, FAULT}, 8'h01);

    // Serve north, then go red again: stuck sensor still forces T
    RN = 1'b0;
    tick(1);
    check("dn_served", {7'b0, DN}, 8'h00);
    tick(1);
    check("t_east_side", {7'b0, T}, 8'h00);
    RN = 1'b1;
    tick(2);
    check("t_fault_forced", {7'b0, T}, 8'h01);
    check("dn_latch_only", {7'b0, DN}, 8'h00);

    // Release north: F falls at edge 9, fault drops at edge 10
    SN_RAW = 1'b0;
    tick(10);
    check("fault_hold_f_fall", {6'b0, FAULT}, 8'h01);
    tick(1);
    check("fault_cleared", {6'b0, FAULT}, 8'h00);
    tick(1);
    check("t_after_fault", {7'b0, T}, 8'h00);

    // East filtered rise coincides with RN rise: set wins
    RN = 1'b0;
    tick(3);
    SE_RAW = 1'b1;
    tick(10);
    RN = 1'b1;
    tick(1);
    check("de_set_wins", {7'b0, DE}, 8'h01);
    tick(1);
    check("de_stays", {7'b0, DE}, 8'h01);

    // Asynchronous reset with demand latched and stuck counter mid-count
    SN_RAW = 1'b1;
    tick(11);
    check("dn_pre_reset", {7'b0, DN}, 8'h01);
    tick(20);
    #2;
    CLR_N = 1'b0;
    #1;
    check("async_reset_dn", {7'b0, DN}, 8'h00);
    check("async_reset_all", {3'b0, T, DN, DE, FAULT}, 8'h00);

    // Release reset into a bouncing north input: no spurious demand
    tick(2);
    CLR_N = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      SN_RAW = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick(1);
        seen |= DN | T;
      end
      SN_RAW = 1'b0;
      tick(1);
      seen |= DN | T;
    end
    for (int i = 0; i < 12; i++) begin
      tick(1);
      seen |= DN | T;
    end
    check("bounce_after_reset", {7'b0, seen}, 8'h00);
    SN_RAW = 1'b1;
    tick(10);
    check("dn_recover_pre", {7'b0, DN}, 8'h00);
    tick(1);
    check("dn_recover", {7'b0, DN}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
